// File: rtl/fp_multiply_pipe.sv
// Three-stage IEEE-754 style multiplier: unpack, multiply, round/pack.
// Define FPMUL_FLAGS_EN to add the registered oFlags output.
module fp_multiply_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [EXP_W+MAN_W:0] iA,
  input  logic [EXP_W+MAN_W:0] iB,
  input  logic                 iValid,
  output logic                 oDone,
  output logic [EXP_W+MAN_W:0] oZ
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [3:0]           oFlags
`endif
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int MW1 = MAN_W + 1;
  localparam int PW  = 2 * MW1;

  localparam logic [EW2-1:0] BIAS =
    EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW2-1:0] EMAX =
    EW2'((1 << EXP_W) - 1);

  typedef struct packed {
    logic           sign;
    logic           nan;
    logic           inf;
    logic           zero;
`ifdef FPMUL_FLAGS_EN
    logic           invalid;
`endif
    logic [EW2-1:0] exp;
    logic [MW1-1:0] ma;
    logic [MW1-1:0] mb;
  } s1_t;

  typedef struct packed {
    logic           sign;
    logic           nan;
    logic           inf;
    logic           zero;
`ifdef FPMUL_FLAGS_EN
    logic           invalid;
`endif
    logic [EW2-1:0] exp;
    logic [PW-1:0]  prod;
  } s2_t;

  logic v1;
  logic v2;
  s1_t  r1;
  s1_t  s1_n;
  s2_t  r2;
  s2_t  s2_n;

  logic             sa;
  logic             sb;
  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W-1:0] fa;
  logic [MAN_W-1:0] fb;
  logic             a_zero;
  logic             b_zero;
  logic             a_inf;
  logic             b_inf;
  logic             a_nan;
  logic             b_nan;
  logic             inv;

  assign {sa, ea, fa} = iA;
  assign {sb, eb, fb} = iB;

  // Subnormals are folded into zero here.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign inv    = (a_inf & b_zero) | (b_inf & a_zero);

  always_comb begin
    s1_n      = '0;
    s1_n.sign = sa ^ sb;
    s1_n.nan  = a_nan | b_nan | inv;
    s1_n.inf  = (a_inf | b_inf) & ~s1_n.nan;
    s1_n.zero = (a_zero | b_zero)
              & ~(a_nan | b_nan | a_inf | b_inf);
`ifdef FPMUL_FLAGS_EN
    s1_n.invalid = inv;
`endif
    s1_n.exp  = {2'b00, ea} + {2'b00, eb} - BIAS;
    s1_n.ma   = {1'b1, fa};
    s1_n.mb   = {1'b1, fb};
  end

  always_comb begin
    s2_n      = '0;
    s2_n.sign = r1.sign;
    s2_n.nan  = r1.nan;
    s2_n.inf  = r1.inf;
    s2_n.zero = r1.zero;
`ifdef FPMUL_FLAGS_EN
    s2_n.invalid = r1.invalid;
`endif
    s2_n.exp  = r1.exp;
    s2_n.prod = PW'(r1.ma) * PW'(r1.mb);
  end

  logic             top;
  logic [PW-1:0]    norm;
  logic [EW2-1:0]   e_n;
  logic [EW2-1:0]   e_f;
  logic [MW1-1:0]   m;
  logic [MW1:0]     m_r;
  logic [MAN_W-1:0] frac;
  logic             g;
  logic             rb;
  logic             st;
  logic             up;
  logic             carry;
  logic             is_ovf;
  logic             is_unf;
  logic [W-1:0]     z_n;

  // Product lies in [1,4); bring the leading one to the MSB.
  assign top   = r2.prod[PW-1];
  assign norm  = top ? r2.prod : {r2.prod[PW-2:0], 1'b0};
  assign e_n   = r2.exp + {{(EW2-1){1'b0}}, top};
  assign m     = norm[PW-1:MAN_W+1];
  assign g     = norm[MAN_W];
  assign rb    = norm[MAN_W-1];
  assign st    = |norm[MAN_W-2:0];
  assign up    = g & (rb | st | m[0]);
  assign m_r   = {1'b0, m} + {{MW1{1'b0}}, up};
  assign carry = m_r[MW1];
  assign frac  = carry ? m_r[MAN_W:1] : m_r[MAN_W-1:0];
  assign e_f   = e_n + {{(EW2-1){1'b0}}, carry};

  assign is_ovf = ~e_f[EW2-1] && (e_f >= EMAX);
  assign is_unf = e_f[EW2-1] || (e_f == '0);

  always_comb begin
    z_n = {r2.sign, e_f[EXP_W-1:0], frac};
    if (r2.nan)
      z_n = {1'b0, {EXP_W{1'b1}}, 1'b1,
             {(MAN_W-1){1'b0}}};
    else if (r2.inf || is_ovf)
      z_n = {r2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (r2.zero || is_unf)
      z_n = {r2.sign, {(EXP_W+MAN_W){1'b0}}};
  end

  always_ff @(posedge clk) begin
    r1 <= s1_n;
    r2 <= s2_n;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      oDone <= 1'b0;
      oZ    <= '0;
    end else begin
      v1    <= iValid;
      v2    <= v1;
      oDone <= v2;
      if (v2) oZ <= z_n;
    end
  end

`ifdef FPMUL_FLAGS_EN
  logic       special;
  logic       f_ovf;
  logic       f_unf;
  logic       f_inx;
  logic [3:0] flags_n;

  assign special = r2.nan | r2.inf | r2.zero;
  assign f_ovf   = ~special & is_ovf;
  assign f_unf   = ~special & ~is_ovf & is_unf;
  assign f_inx   = f_ovf | f_unf
                 | (~special & (g | rb | st));
  assign flags_n = {r2.invalid, f_ovf, f_unf, f_inx};

  always_ff @(posedge clk) begin
    if (!resetn) oFlags <= '0;
    else if (v2) oFlags <= flags_n;
  end
`endif

endmodule

// File: tb/tb_fp_multiply_pipe.sv
// Directed bench for fp_multiply_pipe: single and double precision.
// Flag checks are compiled in when FPMUL_FLAGS_EN is defined.
module tb_fp_multiply_pipe;

  logic        clk;
  logic        resetn;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;
  logic        valid;
  logic        done;
  logic [63:0] da;
  logic [63:0] db;
  logic [63:0] dz;
  logic        dvalid;
  logic        ddone;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]  flags;
  logic [3:0]  dflags;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fp_multiply_pipe u_sp (
    .clk    (clk),
    .resetn (resetn),
    .iA     (a),
    .iB     (b),
    .iValid (valid),
    .oDone  (done),
    .oZ     (z)
`ifdef FPMUL_FLAGS_EN
    ,
    .oFlags (flags)
`endif
  );

  fp_multiply_pipe #(
    .EXP_W (11),
    .MAN_W (52)
  ) u_dp (
    .clk    (clk),
    .resetn (resetn),
    .iA     (da),
    .iB     (db),
    .iValid (dvalid),
    .oDone  (ddone),
    .oZ     (dz)
`ifdef FPMUL_FLAGS_EN
    ,
    .oFlags (dflags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    resetn = 1'b0;
    valid  = 1'b1;
    dvalid = 1'b1;
    a  = 32'h3F800000;
    b  = 32'h3F800000;
    da = 64'h3FF0000000000000;
    db = 64'h3FF0000000000000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    n_cmp++;
    if (z !== 32'h0) begin
      n_err++;
      $display("FAIL reset_z: got %h want 0", z);
    end
    n_cmp++;
    if (ddone !== 1'b0 || dz !== 64'h0) begin
      n_err++;
      $display("FAIL reset_dp: got %b/%h want 0/0",
               ddone, dz);
    end
`ifdef FPMUL_FLAGS_EN
    n_cmp++;
    if (flags !== 4'h0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000", flags);
    end
`endif
    valid  = 1'b0;
    dvalid = 1'b0;
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ignored: got %b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 32'h41480000; b = 32'h41080000; valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_lat1: got %b want 0", done);
    end
    a = 32'hC2480000; b = 32'h41080000;
    @(negedge clk);
    valid = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_lat2: got %b want 0", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || z !== 32'h42D48000) begin
      n_err++;
      $display("FAIL b2b_first: got %b/%h want 1/42d48000",
               done, z);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || z !== 32'hC3D48000) begin
      n_err++;
      $display("FAIL b2b_second: got %b/%h want 1/c3d48000",
               done, z);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || z !== 32'hC3D48000) begin
      n_err++;
      $display("FAIL b2b_hold: got %b/%h want 0/c3d48000",
               done, z);
    end
  endtask

  task automatic test_special_cases();
    localparam int N = 11;
    logic [31:0] va [N] = '{
      32'h3F800001, 32'h7F000000, 32'h00800000,
      32'h7F800000, 32'hFF800000, 32'h80000000,
      32'h00000001, 32'h7FC00001, 32'h3F800001,
      32'h3F800003, 32'h00000000};
    logic [31:0] vb [N] = '{
      32'h3F800001, 32'h40000000, 32'h3F000000,
      32'h00000000, 32'h40000000, 32'h40000000,
      32'hBF800000, 32'h3F800000, 32'h3FC00000,
      32'h3FC00000, 32'hFF800000};
    logic [31:0] vz [N] = '{
      32'h3F800002, 32'h7F800000, 32'h00000000,
      32'h7FC00000, 32'hFF800000, 32'h80000000,
      32'h80000000, 32'h7FC00000, 32'h3FC00002,
      32'h3FC00004, 32'h7FC00000};
`ifdef FPMUL_FLAGS_EN
    logic [3:0] vf [N] = '{
      4'b0001, 4'b0101, 4'b0011,
      4'b1000, 4'b0000, 4'b0000,
      4'b0000, 4'b0000, 4'b0001,
      4'b0001, 4'b1000};
`endif
    logic exp_done;
    @(negedge clk);
    a = va[0]; b = vb[0]; valid = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      exp_done = (c >= 2) && (c < N + 2);
      n_cmp++;
      if (done !== exp_done) begin
        n_err++;
        $display("FAIL spec_done[%0d]: got %b want %b",
                 c, done, exp_done);
      end
      if (exp_done) begin
        n_cmp++;
        if (z !== vz[c-2]) begin
          n_err++;
          $display("FAIL spec_z[%0d]: got %h want %h",
                   c - 2, z, vz[c-2]);
        end
`ifdef FPMUL_FLAGS_EN
        n_cmp++;
        if (flags !== vf[c-2]) begin
          n_err++;
          $display("FAIL spec_flags[%0d]: got %b want %b",
                   c - 2, flags, vf[c-2]);
        end
`endif
      end
      if (c + 1 < N) begin
        a = va[c+1]; b = vb[c+1];
      end else begin
        valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    a = 32'h41480000; b = 32'h41080000; valid = 1'b1;
    @(negedge clk);
    a = 32'h3F800001; b = 32'h3F800001;
    @(negedge clk);
    a = 32'h7F000000; b = 32'h40000000;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    valid  = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || z !== 32'h0) begin
      n_err++;
      $display("FAIL flush_clear: got %b/%h want 0/0",
               done, z);
    end
`ifdef FPMUL_FLAGS_EN
    n_cmp++;
    if (flags !== 4'h0) begin
      n_err++;
      $display("FAIL flush_flags: got %b want 0000", flags);
    end
`endif
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL flush_nodone[%0d]: got %b want 0",
                 c, done);
      end
    end
  endtask

  task automatic test_double();
    @(negedge clk);
    da = 64'h4029000000000000;
    db = 64'h4021000000000000;
    dvalid = 1'b1;
    @(negedge clk);
    da = 64'hC049000000000000;
    db = 64'h4021000000000000;
    @(negedge clk);
    dvalid = 1'b0;
    n_cmp++;
    if (ddone !== 1'b0) begin
      n_err++;
      $display("FAIL dp_lat: got %b want 0", ddone);
    end
    @(negedge clk);
    n_cmp++;
    if (ddone !== 1'b1 || dz !== 64'h405A900000000000) begin
      n_err++;
      $display("FAIL dp_first: got %b/%h want 1/405a900000000000",
               ddone, dz);
    end
    @(negedge clk);
    n_cmp++;
    if (ddone !== 1'b1 || dz !== 64'hC07A900000000000) begin
      n_err++;
      $display("FAIL dp_second: got %b/%h want 1/c07a900000000000",
               ddone, dz);
    end
`ifdef FPMUL_FLAGS_EN
    n_cmp++;
    if (dflags !== 4'h0) begin
      n_err++;
      $display("FAIL dp_flags: got %b want 0000", dflags);
    end
`endif
    @(negedge clk);
    n_cmp++;
    if (ddone !== 1'b0) begin
      n_err++;
      $display("FAIL dp_end: got %b want 0", ddone);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_special_cases();
    test_reset_flush();
    test_double();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
